// File: rtl/gpio_ctrl_pkg.sv
// rtl/gpio_ctrl_pkg.sv - shared register offsets, constants and decode helper for gpio_ctrl
package gpio_ctrl_pkg;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  // Word offsets within the GPIO window; only bits [4:2] are decoded.
  localparam logic [4:0] GPIO_DIR     = 5'h00;
  localparam logic [4:0] GPIO_OUT     = 5'h04;
  localparam logic [4:0] GPIO_IN      = 5'h08;
  localparam logic [4:0] GPIO_RISE_EN = 5'h0C;
  localparam logic [4:0] GPIO_FALL_EN = 5'h10;
  localparam logic [4:0] GPIO_PEND    = 5'h14;
  localparam logic [4:0] GPIO_DB      = 5'h18;

  typedef enum logic [2:0] {
    SEL_DIR,
    SEL_OUT,
    SEL_IN,
    SEL_RISE_EN,
    SEL_FALL_EN,
    SEL_PEND,
    SEL_DB,
    SEL_RSVD
  } reg_sel_e;

  // Offset bits above [4] alias and [1:0] are byte lanes, so only [4:2] matter.
  function automatic reg_sel_e decode_sel(input logic [2:0] word_idx);
    case ({word_idx, 2'b00})
      GPIO_DIR:     return SEL_DIR;
      GPIO_OUT:     return SEL_OUT;
      GPIO_IN:      return SEL_IN;
      GPIO_RISE_EN: return SEL_RISE_EN;
      GPIO_FALL_EN: return SEL_FALL_EN;
      GPIO_PEND:    return SEL_PEND;
      GPIO_DB:      return SEL_DB;
      default:      return SEL_RSVD;
    endcase
  endfunction

endpackage

// File: rtl/gpio_ctrl_if.sv
// rtl/gpio_ctrl_if.sv - simple write/read register bus between bus fabric and gpio_ctrl
interface gpio_ctrl_if;
  logic        wr_en_i;
  logic [31:0] wr_addr_i;
  logic [31:0] wr_data_i;
  logic [31:0] rd_addr_i;
  logic [31:0] rd_data_o;

  modport master (
    output wr_en_i, wr_addr_i, wr_data_i, rd_addr_i,
    input  rd_data_o
  );

  modport slave (
    input  wr_en_i, wr_addr_i, wr_data_i, rd_addr_i,
    output rd_data_o
  );
endinterface

// File: rtl/gpio_ctrl_in_filter.sv
// rtl/gpio_ctrl_in_filter.sv - pin synchronizer, debounce prescaler and filtered edge detect
module gpio_in_filter #(
  parameter int GPIO_WIDTH = 8,
  parameter int DB_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [GPIO_WIDTH-1:0] gpio_i,
  input  logic [DB_WIDTH-1:0]   db,
  input  logic                  db_wr,
  output logic [GPIO_WIDTH-1:0] filt,
  output logic [GPIO_WIDTH-1:0] rise,
  output logic [GPIO_WIDTH-1:0] fall
);

  logic [GPIO_WIDTH-1:0] meta;
  logic [GPIO_WIDTH-1:0] sync;
  logic [GPIO_WIDTH-1:0] smp;
  logic [DB_WIDTH-1:0]   cnt;
  logic                  tick;
  logic [GPIO_WIDTH-1:0] accept;

  assign tick = (cnt == db);

  // A pin is accepted when two consecutive ticks agree and differ from filt.
  // rise/fall are the next-state changes so PEND sets on the same edge as filt.
  assign accept = tick ? (~(smp ^ sync) & (sync ^ filt)) : '0;
  assign rise   = accept & sync;
  assign fall   = accept & ~sync;

  // Synchronizer, prescaler (restarted by DB writes), tick sample and filtered value.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      sync <= '0;
      smp  <= '0;
      filt <= '0;
      cnt  <= '0;
    end else begin
      meta <= gpio_i;
      sync <= meta;
      if (db_wr || tick) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + {{(DB_WIDTH-1){1'b0}}, 1'b1};
      end
      if (tick) begin
        smp <= sync;
      end
      filt <= filt ^ accept;
    end
  end

endmodule

// File: rtl/gpio_ctrl.sv
// rtl/gpio_ctrl.sv - GPIO peripheral: direction/output regs, debounced inputs, edge interrupts
module gpio_ctrl
  import gpio_ctrl_pkg::*;
#(
  parameter int GPIO_WIDTH = 8,
  parameter int DB_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  gpio_ctrl_if.slave            bus,
  input  logic [GPIO_WIDTH-1:0] gpio_i,
  output logic [GPIO_WIDTH-1:0] gpio_o,
  output logic [GPIO_WIDTH-1:0] gpio_oe_o,
  output logic                  irq_o
);

  logic [GPIO_WIDTH-1:0] dir_q;
  logic [GPIO_WIDTH-1:0] out_q;
  logic [GPIO_WIDTH-1:0] rise_en_q;
  logic [GPIO_WIDTH-1:0] fall_en_q;
  logic [GPIO_WIDTH-1:0] pend_q;
  logic [DB_WIDTH-1:0]   db_q;
  logic [31:0]           rd_mux;

  logic [GPIO_WIDTH-1:0] filt;
  logic [GPIO_WIDTH-1:0] rise;
  logic [GPIO_WIDTH-1:0] fall;
  logic [GPIO_WIDTH-1:0] pend_set;
  logic [GPIO_WIDTH-1:0] pend_clr;
  logic [GPIO_WIDTH-1:0] wr_data_g;
  reg_sel_e              wr_sel;
  reg_sel_e              rd_sel;
  logic                  db_wr;
  logic                  unused_bits;

  assign wr_sel    = decode_sel(bus.wr_addr_i[4:2]);
  assign rd_sel    = decode_sel(bus.rd_addr_i[4:2]);
  assign wr_data_g = bus.wr_data_i[GPIO_WIDTH-1:0];
  assign db_wr     = bus.wr_en_i && (wr_sel == SEL_DB);
  assign pend_set  = (rise & rise_en_q) | (fall & fall_en_q);
  assign pend_clr  = (bus.wr_en_i && (wr_sel == SEL_PEND)) ? wr_data_g : '0;

  assign gpio_o    = out_q;
  assign gpio_oe_o = dir_q;
  assign irq_o     = |pend_q;

  // Aliased offset bits and dropped upper data bits are intentionally ignored.
  assign unused_bits = ^{bus.wr_addr_i[31:5], bus.wr_addr_i[1:0],
                         bus.rd_addr_i[31:5], bus.rd_addr_i[1:0], bus.wr_data_i};

  gpio_in_filter #(
    .GPIO_WIDTH (GPIO_WIDTH),
    .DB_WIDTH   (DB_WIDTH)
  ) u_in_filter (
    .clk    (clk),
    .rst    (rst),
    .gpio_i (gpio_i),
    .db     (db_q),
    .db_wr  (db_wr),
    .filt   (filt),
    .rise   (rise),
    .fall   (fall)
  );

  // Register file writes; PEND gives a same-cycle edge set priority over W1C.
  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q     <= '0;
      out_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      db_q      <= '0;
      pend_q    <= '0;
    end else begin
      if (bus.wr_en_i) begin
        case (wr_sel)
          SEL_DIR:     dir_q     <= wr_data_g;
          SEL_OUT:     out_q     <= wr_data_g;
          SEL_RISE_EN: rise_en_q <= wr_data_g;
          SEL_FALL_EN: fall_en_q <= wr_data_g;
          SEL_DB:      db_q      <= bus.wr_data_i[DB_WIDTH-1:0];
          default:     ;
        endcase
      end
      pend_q <= (pend_q & ~pend_clr) | pend_set;
    end
  end

  // Read mux from pre-write register values, zero-extended to the bus width.
  always_comb begin
    rd_mux = ZERO_WORD;
    case (rd_sel)
      SEL_DIR:     rd_mux[GPIO_WIDTH-1:0] = dir_q;
      SEL_OUT:     rd_mux[GPIO_WIDTH-1:0] = out_q;
      SEL_IN:      rd_mux[GPIO_WIDTH-1:0] = filt;
      SEL_RISE_EN: rd_mux[GPIO_WIDTH-1:0] = rise_en_q;
      SEL_FALL_EN: rd_mux[GPIO_WIDTH-1:0] = fall_en_q;
      SEL_PEND:    rd_mux[GPIO_WIDTH-1:0] = pend_q;
      SEL_DB:      rd_mux[DB_WIDTH-1:0]   = db_q;
      default:     rd_mux = ZERO_WORD;
    endcase
  end

  // Read data reloads every cycle; there is no read enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rd_data_o <= ZERO_WORD;
    end else begin
      bus.rd_data_o <= rd_mux;
    end
  end

endmodule
